// File: rtl/adc_pkg.sv
// Shared definitions for the multi-channel ADC sequencer: FSM encoding and default sample width.
package adc_pkg;

    localparam int DEF_DW = 10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SELECT = 2'd1;
    localparam state_t ST_ARM    = 2'd2;
    localparam state_t ST_WAIT   = 2'd3;

endpackage

// File: rtl/adc_sync_edge.sv
// Two-flop synchroniser for an asynchronous ADC handshake line, plus a rising-edge detector.
module adc_sync_edge (
    input  logic clk,
    input  logic areset,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [2:0] sh;

    // NOTE: non-blocking shift so each flop samples its predecessor's value from before the edge.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sh <= '0;
        end else begin
            sh <= {sh[1:0], d};
        end
    end

    assign level = sh[1];
    assign rise  = sh[1] & ~sh[2];

endmodule

// File: rtl/adc_seq_controller.sv
// Round-robin multi-channel ADC sequencer: selects, starts, waits for data, optionally averages,
// and publishes one tagged result strobe per channel, with a per-conversion timeout.
module adc_seq_controller #(
    parameter int DW       = adc_pkg::DEF_DW,
    parameter int NCH      = 4,
    parameter int CHW      = 2,
    parameter int AVG_LOG2 = 0,
    parameter int TO_W     = 8
) (
    input  logic           clk,
    input  logic           areset,
    input  logic           adc_en,
    input  logic [NCH-1:0] ch_mask,
    input  logic           adc_ready,
    input  logic           adc_dvalid,
    input  logic [DW-1:0]  adc_data_in,
    output logic           adc_start,
    output logic [CHW-1:0] adc_ch_sel,
    output logic [DW-1:0]  adc_data_out,
    output logic [CHW-1:0] adc_ch_out,
    output logic           adc_strb,
    output logic           adc_timeout,
    output logic           busy
);

    import adc_pkg::*;

    localparam int AW    = DW + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((64'd1 << TO_W) - 64'd2);

    state_t           state;
    logic [CHW-1:0]   ptr;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    sum;
    logic [CNT_W-1:0] cnt;
    logic [TO_W-1:0]  to_cnt;

    logic ready_s;
    logic dv_rise;
    logic unused_ready_rise;
    logic unused_dv_level;

    adc_sync_edge u_ready_sync (
        .clk    (clk),
        .areset (areset),
        .d      (adc_ready),
        .level  (ready_s),
        .rise   (unused_ready_rise)
    );

    adc_sync_edge u_dvalid_sync (
        .clk    (clk),
        .areset (areset),
        .d      (adc_dvalid),
        .level  (unused_dv_level),
        .rise   (dv_rise)
    );

    // First enabled channel at or after 'from', wrapping at NCH.
    function automatic logic [CHW-1:0] next_ch(input logic [NCH-1:0] mask,
                                               input logic [CHW-1:0] from);
        logic [CHW-1:0] pick;
        logic [NCH-1:0] rot;
        logic           hit;
        int             idx;
        pick = from;
        hit  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(from) + i) % NCH;
            rot = mask >> idx;
            if (!hit && rot[0]) begin
                pick = CHW'(idx);
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [CHW-1:0] wrap_inc(input logic [CHW-1:0] ch);
        return (int'(ch) == NCH - 1) ? '0 : ch + CHW'(1);
    endfunction

    assign sum  = acc + AW'(adc_data_in);
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            acc          <= '0;
            cnt          <= '0;
            to_cnt       <= '0;
            adc_start    <= 1'b0;
            adc_ch_sel   <= '0;
            adc_data_out <= '0;
            adc_ch_out   <= '0;
            adc_strb     <= 1'b0;
            adc_timeout  <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle, so any branch that raises one yields a single-cycle strobe.
            adc_start   <= 1'b0;
            adc_strb    <= 1'b0;
            adc_timeout <= 1'b0;

            if (state != ST_IDLE && !adc_en) begin
                state <= ST_IDLE;
                acc   <= '0;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (adc_en && (|ch_mask)) state <= ST_SELECT;
                    end
                    ST_SELECT: begin
                        if (|ch_mask) begin
                            adc_ch_sel <= next_ch(ch_mask, ptr);
                            state      <= ST_ARM;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_ARM: begin
                        if (ready_s) begin
                            adc_start <= 1'b1;
                            to_cnt    <= '0;
                            state     <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        // A sample arriving on the timeout cycle takes priority.
                        if (dv_rise) begin
                            if (cnt == CNT_LAST) begin
                                adc_data_out <= DW'(sum >> AVG_LOG2);
                                adc_ch_out   <= adc_ch_sel;
                                adc_strb     <= 1'b1;
                                acc          <= '0;
                                cnt          <= '0;
                                ptr          <= wrap_inc(adc_ch_sel);
                                state        <= ST_SELECT;
                            end else begin
                                acc   <= sum;
                                cnt   <= cnt + CNT_W'(1);
                                state <= ST_ARM;
                            end
                        end else if (to_cnt == TO_LAST) begin
                            adc_timeout <= 1'b1;
                            acc         <= '0;
                            cnt         <= '0;
                            ptr         <= wrap_inc(adc_ch_sel);
                            state       <= ST_SELECT;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_seq_controller.sv
// Directed bench: instance A (no averaging, short timeout) and instance B (4-sample averaging).
module tb_adc_seq_controller;

    localparam int DW  = 10;
    localparam int NCH = 4;
    localparam int CHW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A ----------------
    logic           rst_a = 1'b0, en_a = 1'b0, ready_a = 1'b1, dvalid_a = 1'b0;
    logic [NCH-1:0] mask_a = '0;
    logic [DW-1:0]  din_a = '0;
    logic           start_a, strb_a, to_a, busy_a;
    logic [CHW-1:0] sel_a, chout_a;
    logic [DW-1:0]  dout_a;

    adc_seq_controller #(.DW(DW), .NCH(NCH), .CHW(CHW), .AVG_LOG2(0), .TO_W(4)) dut_a (
        .clk          (clk),
        .areset       (rst_a),
        .adc_en       (en_a),
        .ch_mask      (mask_a),
        .adc_ready    (ready_a),
        .adc_dvalid   (dvalid_a),
        .adc_data_in  (din_a),
        .adc_start    (start_a),
        .adc_ch_sel   (sel_a),
        .adc_data_out (dout_a),
        .adc_ch_out   (chout_a),
        .adc_strb     (strb_a),
        .adc_timeout  (to_a),
        .busy         (busy_a)
    );

    // ---------------- instance B ----------------
    logic           rst_b = 1'b0, en_b = 1'b0, ready_b = 1'b1, dvalid_b = 1'b0;
    logic [NCH-1:0] mask_b = '0;
    logic [DW-1:0]  din_b = '0;
    logic           start_b, strb_b, to_b, busy_b;
    logic [CHW-1:0] sel_b, chout_b;
    logic [DW-1:0]  dout_b;

    adc_seq_controller #(.DW(DW), .NCH(NCH), .CHW(CHW), .AVG_LOG2(2), .TO_W(8)) dut_b (
        .clk          (clk),
        .areset       (rst_b),
        .adc_en       (en_b),
        .ch_mask      (mask_b),
        .adc_ready    (ready_b),
        .adc_dvalid   (dvalid_b),
        .adc_data_in  (din_b),
        .adc_start    (start_b),
        .adc_ch_sel   (sel_b),
        .adc_data_out (dout_b),
        .adc_ch_out   (chout_b),
        .adc_strb     (strb_b),
        .adc_timeout  (to_b),
        .busy         (busy_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // ADC models: answer a start pulse two cycles later, hold dvalid for four cycles.
    bit             mute_a = 1'b0, mute_b = 1'b0;
    int             dly_a = 0, hold_a = 0, dly_b = 0, hold_b = 0;
    logic [CHW-1:0] ch_a = '0;
    int             delivered_b = 0;
    logic [DW-1:0]  tbl_b [0:15] = '{100, 101, 102, 104, 50, 60, 200, 200, 200, 204,
                                     7, 9, 40, 40, 40, 40};

    always @(negedge clk) begin
        if (hold_a > 0) begin
            hold_a--;
            if (hold_a == 0) dvalid_a = 1'b0;
        end
        if (dly_a > 0) begin
            dly_a--;
            if (dly_a == 0) begin
                din_a    = DW'(10 * int'(ch_a));
                dvalid_a = 1'b1;
                hold_a   = 4;
            end
        end
        if (start_a === 1'b1 && !mute_a) begin
            dly_a = 2;
            ch_a  = sel_a;
        end
    end

    always @(negedge clk) begin
        if (hold_b > 0) begin
            hold_b--;
            if (hold_b == 0) dvalid_b = 1'b0;
        end
        if (dly_b > 0) begin
            dly_b--;
            if (dly_b == 0) begin
                din_b    = (delivered_b < 16) ? tbl_b[delivered_b] : '0;
                dvalid_b = 1'b1;
                hold_b   = 4;
                delivered_b++;
            end
        end
        if (start_b === 1'b1 && !mute_b) dly_b = 2;
    end

    // Output monitors.
    int             strb_cnt_a = 0, start_cnt_a = 0, to_cnt_a = 0, dbl_a = 0, bad_sel_a = 0;
    int             start_cyc_a = 0, to_cyc_a = 0;
    logic [CHW-1:0] last_sel_a = '0;
    bit             prev_start_a = 1'b0;
    int             q_ch_a[$], q_dat_a[$];

    always @(negedge clk) begin
        if (strb_a === 1'b1) begin
            strb_cnt_a++;
            q_ch_a.push_back(int'(chout_a));
            q_dat_a.push_back(int'(dout_a));
        end
        if (start_a === 1'b1) begin
            start_cnt_a++;
            last_sel_a  = sel_a;
            start_cyc_a = cyc;
            if (sel_a == 2'd0 || sel_a == 2'd2) bad_sel_a++;
            if (prev_start_a) dbl_a++;
        end
        prev_start_a = (start_a === 1'b1);
        if (to_a === 1'b1) begin
            to_cnt_a++;
            to_cyc_a = cyc;
        end
    end

    int             strb_cnt_b = 0, start_cnt_b = 0, dbl_b = 0;
    logic [CHW-1:0] last_sel_b = '0;
    bit             prev_start_b = 1'b0;

    always @(negedge clk) begin
        if (strb_b === 1'b1) strb_cnt_b++;
        if (start_b === 1'b1) begin
            start_cnt_b++;
            last_sel_b = sel_b;
            if (prev_start_b) dbl_b++;
        end
        prev_start_b = (start_b === 1'b1);
    end

    int exp_ch1 [0:4] = '{0, 1, 2, 3, 0};
    int exp_ch2 [0:3] = '{1, 3, 1, 3};

    initial begin
        int s0, t0, sc, b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick(3);
        check("rst_a_outs", 32'({dout_a, chout_a, sel_a, strb_a, to_a, start_a, busy_a}), 0);
        check("rst_b_outs", 32'({dout_b, chout_b, sel_b, strb_b, to_b, start_b, busy_b}), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick(2);
        check("idle_busy", 32'(busy_a), 0);

        // A: all channels, data = 10*ch.
        mask_a = 4'b1111;
        en_a   = 1'b1;
        for (int i = 0; i < 400 && strb_cnt_a < 5; i++) tick(1);
        en_a = 1'b0;
        check("a1_strobes", strb_cnt_a, 5);
        check("a1_starts", start_cnt_a, 5);
        for (int i = 0; i < 5 && i < q_ch_a.size(); i++) begin
            check($sformatf("a1_ch%0d", i), q_ch_a[i], exp_ch1[i]);
            check($sformatf("a1_data%0d", i), q_dat_a[i], 10 * exp_ch1[i]);
        end

        // A: sparse mask 1010, pointer kept across the disable.
        tick(3);
        check("a2_idle", 32'(busy_a), 0);
        b0     = bad_sel_a;
        s0     = strb_cnt_a;
        mask_a = 4'b1010;
        en_a   = 1'b1;
        for (int i = 0; i < 400 && strb_cnt_a < s0 + 4; i++) tick(1);
        en_a = 1'b0;
        check("a2_strobes", strb_cnt_a, s0 + 4);
        for (int i = 0; i < 4 && s0 + i < q_ch_a.size(); i++) begin
            check($sformatf("a2_ch%0d", i), q_ch_a[s0 + i], exp_ch2[i]);
            check($sformatf("a2_data%0d", i), q_dat_a[s0 + i], 10 * exp_ch2[i]);
        end
        check("a2_bad_sel", bad_sel_a - b0, 0);

        // A: ADC silent -> timeout after 15 WAIT cycles, then the next channel.
        tick(3);
        mute_a = 1'b1;
        mask_a = 4'b1111;
        en_a   = 1'b1;
        s0     = strb_cnt_a;
        t0     = to_cnt_a;
        for (int i = 0; i < 100 && to_cnt_a == t0; i++) tick(1);
        check("a3_to_seen", to_cnt_a, t0 + 1);
        check("a3_to_lat", to_cyc_a - start_cyc_a, 15);
        check("a3_to_chan", 32'(last_sel_a), 0);
        sc = start_cnt_a;
        for (int i = 0; i < 20 && start_cnt_a == sc; i++) tick(1);
        check("a3_next_sel", 32'(last_sel_a), 1);
        mute_a = 1'b0;
        for (int i = 0; i < 100 && strb_cnt_a == s0; i++) tick(1);
        check("a3_strobes", strb_cnt_a, s0 + 1);
        if (s0 < q_ch_a.size()) begin
            check("a3_resume_ch", q_ch_a[s0], 2);
            check("a3_resume_data", q_dat_a[s0], 20);
        end
        check("a3_to_total", to_cnt_a, t0 + 2);
        en_a = 1'b0;

        // B: 4-sample average on channel 0: 100+101+102+104 = 407 -> 101.
        mask_b = 4'b0001;
        en_b   = 1'b1;
        for (int i = 0; i < 500 && strb_cnt_b < 1; i++) tick(1);
        check("b1_strobes", strb_cnt_b, 1);
        check("b1_data", 32'(dout_b), 101);
        check("b1_ch", 32'(chout_b), 0);
        check("b1_starts", start_cnt_b, 4);

        // B: disable after 2 of 4 samples; partial result must be discarded.
        for (int i = 0; i < 200 && delivered_b < 6; i++) tick(1);
        mute_b = 1'b1;
        tick(10);
        en_b = 1'b0;
        tick(4);
        check("b5_idle", 32'(busy_b), 0);
        check("b5_no_strobe", strb_cnt_b, 1);
        check("b5_hold_data", 32'(dout_b), 101);
        sc     = start_cnt_b;
        mute_b = 1'b0;
        en_b   = 1'b1;
        for (int i = 0; i < 500 && strb_cnt_b < 2; i++) tick(1);
        check("b5_strobes", strb_cnt_b, 2);
        check("b5_data", 32'(dout_b), 201);
        check("b5_ch", 32'(chout_b), 0);
        check("b5_starts", start_cnt_b - sc, 4);

        // B: reset mid-WAIT with a non-zero accumulator on channel 1.
        mask_b = 4'b1111;
        for (int i = 0; i < 200 && delivered_b < 12; i++) tick(1);
        mute_b = 1'b1;
        tick(10);
        check("b6_pre_sel", 32'(sel_b), 1);
        check("b6_pre_busy", 32'(busy_b), 1);
        rst_b = 1'b1;
        #1;
        check("b6_rst_data", 32'(dout_b), 0);
        check("b6_rst_outs", 32'({chout_b, sel_b, strb_b, to_b, start_b, busy_b}), 0);
        tick(2);
        rst_b  = 1'b0;
        mute_b = 1'b0;
        sc     = start_cnt_b;
        for (int i = 0; i < 50 && start_cnt_b == sc; i++) tick(1);
        check("b6_first_sel", 32'(last_sel_b), 0);
        for (int i = 0; i < 500 && strb_cnt_b < 3; i++) tick(1);
        check("b6_strobes", strb_cnt_b, 3);
        check("b6_data", 32'(dout_b), 40);
        check("b6_ch", 32'(chout_b), 0);

        check("a_double_start", dbl_a, 0);
        check("b_double_start", dbl_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
